// File: rtl/main_memory_if.sv
// Request/response bundle between the cache controller and the backing store.
// The controller drives the master side; main_memory sits on the slave side.
interface main_memory_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              MStrobe;
  logic              MRW;
  logic [ADDR_W-1:0] MAddr;
  logic [DATA_W-1:0] MDataIn;
  logic              LdCtr;
  logic [DATA_W-1:0] MDataOut;
  logic              CtrSig;
  logic              Busy;
  logic              Err;

  modport master (
    output MStrobe, MRW, MAddr, MDataIn, LdCtr,
    input  MDataOut, CtrSig, Busy, Err
  );

  modport slave (
    input  MStrobe, MRW, MAddr, MDataIn, LdCtr,
    output MDataOut, CtrSig, Busy, Err
  );
endinterface

// File: rtl/main_memory.sv
// Backing store with a controller-reloaded wait-state counter; one word per access,
// performed when the count steps from 1 to 0 while a request is pending.
//   state  | meaning
//   S_IDLE | no request pending; a strobe latches the next request
//   S_WAIT | request latched, waiting for the count to expire
module main_memory #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  main_memory_if.slave bus
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      CNT_LOAD  = 4'(WAIT_CYC);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rw_q;
  logic              err;
  logic [DATA_W-1:0] dout;
  logic              latch_req;
  logic              fire;
  logic              flag_err;
  logic              req_ok;
  logic              addr_ok;
  logic [IDX_W-1:0]  idx;

  logic [DATA_W-1:0] mem [DEPTH];

  assign req_ok  = {1'b0, bus.MAddr} < DEPTH_LIM;
  assign addr_ok = {1'b0, addr_q} < DEPTH_LIM;
  assign idx     = addr_q[IDX_W-1:0];

  always_comb begin
    state_nxt = state;
    latch_req = 1'b0;
    fire      = 1'b0;
    flag_err  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.MStrobe) begin
          latch_req = 1'b1;
          flag_err  = ~req_ok;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // a second strobe is dropped; the latched request is kept
        if (bus.MStrobe) flag_err = 1'b1;
        if (!bus.LdCtr && cnt == 4'd1) begin
          fire      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= CNT_LOAD;
      addr_q <= '0;
      data_q <= '0;
      rw_q   <= 1'b0;
      err    <= 1'b0;
      dout   <= '0;
    end else begin
      state <= state_nxt;
      if (bus.LdCtr)       cnt <= CNT_LOAD;
      else if (cnt != 4'd0) cnt <= cnt - 4'd1;
      if (flag_err) err <= 1'b1;
      if (latch_req) begin
        addr_q <= bus.MAddr;
        data_q <= bus.MDataIn;
        rw_q   <= bus.MRW;
      end
      if (fire && !rw_q) dout <= addr_ok ? mem[idx] : '0;
    end
  end

  // array is deliberately unreset; only in-range writes commit
  always_ff @(posedge clk) begin
    if (fire && rw_q && addr_ok) mem[idx] <= data_q;
  end

  assign bus.MDataOut = dout;
  assign bus.CtrSig   = (cnt == 4'd0);
  assign bus.Busy     = (state == S_WAIT);
  assign bus.Err      = err;

endmodule
